instruction_fetch: RTL and testbench

Instruction fetch stage that feeds the decode stage: holds the program counter, issues one word read at a time to instruction memory, and presents each fetched instruction with its PC under a valid/ready handshake. Branch and jump targets computed downstream are applied through a redirect strobe, and any fetch in flight at that moment is discarded. The block sits between instruction memory and decode, so decode sees a stream of instructions instead of a PC.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default reset PC, PC increment and the word-alignment helper.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_WAIT  = 2'd2,
    FS_HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one word read in
// flight to instruction memory and hands each fetched word plus its PC to
// decode over a valid/ready handshake. Redirects replace the PC and any
// response still in flight for the old stream is dropped via the kill flag.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         kill;

  // PC, kill flag, instruction register and FSM advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the instruction register is reset too; it is a single word, not
    // a memory array, so clearing it costs nothing and keeps Ins defined.
    if (!rst_n) begin
      state     <= FS_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      ins       <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge PC/kill values regardless of statement order.
      unique case (state)
        FS_IDLE: begin
          if (redirect) pc <= word_align(redirect_pc);
          state <= FS_FETCH;
        end

        FS_FETCH: begin
          // A redirect alongside acceptance means the accepted read is stale.
          if (redirect) pc <= word_align(redirect_pc);
          if (mem_ack) begin
            state <= FS_WAIT;
            if (redirect) kill <= 1'b1;
          end
        end

        FS_WAIT: begin
          if (mem_rvalid) begin
            if (kill || redirect) begin
              kill  <= 1'b0;
              if (redirect) pc <= word_align(redirect_pc);
              state <= FS_FETCH;
            end else begin
              ins       <= mem_rdata;
              ins_pc    <= pc;
              pc        <= pc + PC_INC;
              ins_valid <= 1'b1;
              state     <= FS_HOLD;
            end
          end else if (redirect) begin
            pc   <= word_align(redirect_pc);
            kill <= 1'b1;
          end
        end

        FS_HOLD: begin
          // Redirect drops an unconsumed instruction; a handshake in the
          // same cycle still completes because both paths leave HOLD.
          if (redirect) pc <= word_align(redirect_pc);
          if (redirect || ins_ready) begin
            ins_valid <= 1'b0;
            state     <= FS_FETCH;
          end
        end

        default: state <= FS_IDLE;
      endcase
    end
  end

  // Memory request decode from registered state only.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves an output
    // unassigned and infers a latch.
    mem_req  = 1'b0;
    mem_addr = pc;
    if (state == FS_FETCH) mem_req = 1'b1;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized memory latency, acks, decode stalls and redirects, all checked
// against a stream-level reference model of the fetch stage.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, mem_req, mem_ack, mem_rvalid, ins_valid, ins_ready;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, ins, ins_pc;

  logic        w_redirect, w_req, w_ack, w_rvalid, w_ins_valid, w_ready;
  logic [31:0] w_redirect_pc, w_addr, w_rdata, w_ins, w_ins_pc;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [31:0] exp_pc;
  bit          pending;
  int          cnt;
  int          k_lat;
  logic [31:0] pend_addr;
  bit          stray;
  bit          prev_valid, prev_ready, prev_redir;
  logic [31:0] prev_ins, prev_ins_pc, s_rpc;
  int          idle_cnt;
  bit          w_acc, w_got;
  logic [31:0] w_acc_addr, w_first_pc, w_first_ins;
  logic [31:0] w_reqs[$];
  logic [31:0] s_ins, s_pc;

  instruction_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .mem_req     (w_req),
    .mem_addr    (w_addr),
    .mem_ack     (w_ack),
    .mem_rvalid  (w_rvalid),
    .mem_rdata   (w_rdata),
    .ins         (w_ins),
    .ins_pc      (w_ins_pc),
    .ins_valid   (w_ins_valid),
    .ins_ready   (w_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_addr",  mem_addr,       DEFAULT_RESET_PC);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_ins",   ins,            32'd0);
    check("rst_inspc", ins_pc,         32'd0);
    check("rst_waddr", w_addr,         WRAP_PC);
  endtask

  task automatic reset_model();
    exp_pc     = DEFAULT_RESET_PC;
    pending    = 1'b0;
    cnt        = 0;
    stray      = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_redir = 1'b0;
    idle_cnt   = 0;
    w_acc      = 1'b0;
    mem_rvalid = 1'b0;
    w_rvalid   = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, apply model updates at the
  // rising edge, then drive the memory responses for the next cycle.
  task automatic tick();
    @(negedge clk);
    check("req_while_valid", 32'(mem_req & ins_valid), 32'd0);
    if (mem_req) begin
      check("req_addr", mem_addr, exp_pc);
      check("one_outstanding", 32'(pending), 32'd0);
    end
    if (ins_valid && !prev_valid) begin
      check("deliver_pc", ins_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (ins_valid) check("ins_data", ins, memf(ins_pc));
    if (prev_valid && !(prev_ready || prev_redir)) begin
      check("hold_valid", 32'(ins_valid), 32'd1);
      check("hold_ins",   ins,    prev_ins);
      check("hold_pc",    ins_pc, prev_ins_pc);
    end
    if (prev_valid && (prev_ready || prev_redir)) begin
      check("release_valid", 32'(ins_valid), 32'd0);
      check("release_req",   32'(mem_req),   32'd1);
    end
    if ((mem_req && mem_ack) || (ins_valid && ins_ready)) idle_cnt = 0;
    else idle_cnt++;
    check("progress", 32'(idle_cnt > 64), 32'd0);
    if (idle_cnt > 64) idle_cnt = 0;

    if (mem_req && mem_ack) begin
      pending   = 1'b1;
      cnt       = k_lat;
      pend_addr = mem_addr;
    end
    prev_valid  = ins_valid;
    prev_ready  = ins_ready;
    prev_redir  = redirect;
    prev_ins    = ins;
    prev_ins_pc = ins_pc;
    s_rpc       = redirect_pc;

    w_acc      = w_req & w_ack;
    w_acc_addr = w_addr;
    if (w_req && w_ack && w_reqs.size() < 2) w_reqs.push_back(w_addr);
    if (w_ins_valid && !w_got) begin
      w_got       = 1'b1;
      w_first_pc  = w_ins_pc;
      w_first_ins = w_ins;
    end

    @(posedge clk);
    if (prev_redir) exp_pc = s_rpc & ~32'h3;
    #1;
    mem_rvalid = stray;
    mem_rdata  = 32'hDEAD_BEEF;
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memf(pend_addr);
        pending    = 1'b0;
      end
    end
    w_rvalid = w_acc;
    w_rdata  = memf(w_acc_addr);
  endtask

  initial begin
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    ins_ready     = 1'b0;
    k_lat         = 1;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_ack         = 1'b0;
    w_ready       = 1'b0;
    w_rdata       = '0;
    w_got         = 1'b0;
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    ins_ready = 1'b1;
    w_ack     = 1'b1;
    w_ready   = 1'b1;
    check("idle_no_req", 32'(mem_req), 32'd0);

    // Basic fetch, k=1, decode always ready
    tick();
    check("first_req",  32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0);
    tick();
    check("wait_no_req", 32'(mem_req), 32'd0);
    tick();
    check("first_valid", 32'(ins_valid), 32'd1);
    check("first_ins",   ins,    32'h2008_0005);
    check("first_inspc", ins_pc, 32'h0);
    tick();
    check("second_req",  32'(mem_req), 32'd1);
    check("second_addr", mem_addr, 32'h4);
    tick();

    // Decode stall in HOLD
    ins_ready = 1'b0;
    tick();
    check("stall_valid0", 32'(ins_valid), 32'd1);
    check("stall_pc0",    ins_pc, 32'h4);
    s_ins = ins;
    s_pc  = ins_pc;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(ins_valid), 32'd1);
      check("stall_ins",   ins,    s_ins);
      check("stall_pc",    ins_pc, s_pc);
      check("stall_noreq", 32'(mem_req), 32'd0);
      tick();
    end
    ins_ready = 1'b1;
    k_lat     = 3;
    tick();
    check("after_stall_req",  32'(mem_req), 32'd1);
    check("after_stall_addr", mem_addr, 32'h8);

    // Redirect in WAIT while the response for 0x8 is pending
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    k_lat    = 1;
    check("kill_wait_noreq", 32'(mem_req),   32'd0);
    check("kill_wait_valid", 32'(ins_valid), 32'd0);
    tick();
    check("kill_rvalid_valid", 32'(ins_valid), 32'd0);
    tick();
    check("redir_req",   32'(mem_req), 32'd1);
    check("redir_addr",  mem_addr, 32'h100);
    check("redir_valid", 32'(ins_valid), 32'd0);
    tick();
    tick();
    check("redir_ins_valid", 32'(ins_valid), 32'd1);
    check("redir_ins_pc",    ins_pc, 32'h100);

    // Redirect in the same cycle as the response
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    check("same_cycle_valid", 32'(ins_valid), 32'd0);
    check("same_cycle_req",   32'(mem_req),   32'd1);
    check("same_cycle_addr",  mem_addr, 32'h40);

    // Reset in the middle of WAIT, then stray responses after release
    k_lat = 3;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    mem_ack    = 1'b0;
    k_lat      = 1;
    stray      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    check("post_rst_noreq", 32'(mem_req),   32'd0);
    check("post_rst_valid", 32'(ins_valid), 32'd0);
    tick();
    check("stray_req",    32'(mem_req),   32'd1);
    check("stray_addr",   mem_addr,       DEFAULT_RESET_PC);
    check("stray_valid1", 32'(ins_valid), 32'd0);
    tick();
    check("stray_valid2", 32'(ins_valid), 32'd0);
    stray   = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    check("post_rst_ins_valid", 32'(ins_valid), 32'd1);
    check("post_rst_ins_pc",    ins_pc, DEFAULT_RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mem_ack     = ($urandom_range(0, 9) < 7);
      ins_ready   = ($urandom_range(0, 9) < 6);
      k_lat       = $urandom_range(1, 4);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      tick();
    end

    // Wrap-around instance: first request at the top word, next at zero
    check("wrap_req_count", 32'(w_reqs.size()), 32'd2);
    if (w_reqs.size() >= 2) begin
      check("wrap_first_addr",  w_reqs[0], WRAP_PC);
      check("wrap_second_addr", w_reqs[1], 32'h0);
    end
    check("wrap_got",       32'(w_got), 32'd1);
    check("wrap_first_pc",  w_first_pc,  WRAP_PC);
    check("wrap_first_ins", w_first_ins, memf(WRAP_PC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
